bp_stream_mmio_arbiter: RTL and testbench

Shares a single 32-bit MMIO stream link (one outbound command stream, one inbound read-data stream) among several local requesters (host bridge, debug, DMA). It grants requesters round-robin, serialises each command as an address beat then a data beat, and records the order in which commands were issued. Responses are routed back to the originating requester in that order. It sits between the requesters and the stream pins of the MMIO bridge.

---
 rtl/bp_stream_arb_pkg.sv | 15 +
 rtl/bp_stream_arb_tag_queue.sv | 49 ++++
 rtl/bp_stream_mmio_arbiter.sv | 135 +++++++++++++
 tb/tb_bp_stream_mmio_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_stream_arb_pkg.sv
// Shared types for the stream MMIO arbiter: issue FSM states and the
// outstanding-command tag recorded per issued command.
package bp_stream_arb_pkg;

  // Wide enough for the largest supported requester count (8).
  localparam int bp_stream_arb_id_width_gp = 3;

  typedef enum logic [1:0] {e_idle, e_addr, e_data} bp_stream_arb_state_e;

  typedef struct packed {
    logic [bp_stream_arb_id_width_gp-1:0] id;
    logic                                 wr;
  } bp_stream_arb_tag_s;

endpackage

// File: rtl/bp_stream_arb_tag_queue.sv
// In-order FIFO of issued-command tags; head selects where the next
// response is routed.
module bp_stream_arb_tag_queue
  import bp_stream_arb_pkg::*;
#(
  parameter int els_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  bp_stream_arb_tag_s data_i,
  input  logic               yumi_i,
  output bp_stream_arb_tag_s data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [ptr_w_lp-1:0] wptr_q, rptr_q;
  logic [ptr_w_lp:0]   cnt_q;
  bp_stream_arb_tag_s  mem_q [els_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (v_i)    wptr_q <= wptr_q + 1'b1;
      if (yumi_i) rptr_q <= rptr_q + 1'b1;
      case ({v_i, yumi_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == (ptr_w_lp+1)'(els_p));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bp_stream_mmio_arbiter.sv
// Round-robin share of one MMIO stream link: each command goes out as an
// address beat then a data beat; responses return in issue order.
module bp_stream_mmio_arbiter
  import bp_stream_arb_pkg::*;
#(
  parameter int num_req_p           = 4,
  parameter int stream_data_width_p = 32,
  parameter int tag_els_p           = 16
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic [num_req_p-1:0]                         req_v_i,
  input  logic [num_req_p-1:0]                         req_wr_i,
  input  logic [num_req_p*stream_data_width_p-1:0]     req_addr_i,
  input  logic [num_req_p*stream_data_width_p-1:0]     req_data_i,
  output logic [num_req_p-1:0]                         req_yumi_o,
  output logic                                         stream_v_o,
  output logic [stream_data_width_p-1:0]               stream_data_o,
  input  logic                                         stream_yumi_i,
  input  logic                                         stream_v_i,
  input  logic [stream_data_width_p-1:0]               stream_data_i,
  output logic                                         stream_ready_o,
  output logic [num_req_p-1:0]                         resp_v_o,
  output logic [stream_data_width_p-1:0]               resp_data_o,
  input  logic [num_req_p-1:0]                         resp_yumi_i
);

  localparam int id_w_lp = $clog2(num_req_p);
  localparam int w_lp    = stream_data_width_p;

  bp_stream_arb_state_e     state_q;
  logic [id_w_lp-1:0]       grant_q, rr_ptr_q, grant_d;
  logic                     wr_q, grant_v;
  logic [w_lp-1:0]          data_q;
  logic                     push, pop, full, empty;
  bp_stream_arb_tag_s       tag_in, head;
  logic [num_req_p-1:0]     head_oh;

  // Round-robin search starting at rr_ptr_q; first valid requester wins.
  always_comb begin
    int idx;
    grant_v = 1'b0;
    grant_d = rr_ptr_q;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!grant_v && req_v_i[idx]) begin
        grant_v = 1'b1;
        grant_d = id_w_lp'(idx);
      end
    end
  end

  // Beat register holds whatever is on the wire, so stream outputs never
  // depend on stream_yumi_i.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_idle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        e_idle: if (grant_v && !full) begin
          grant_q <= grant_d;
          wr_q    <= req_wr_i[grant_d];
          data_q  <= req_addr_i[int'(grant_d)*w_lp +: w_lp];
          state_q <= e_addr;
        end
        e_addr: if (stream_yumi_i) begin
          data_q  <= wr_q ? req_data_i[int'(grant_q)*w_lp +: w_lp] : '0;
          state_q <= e_data;
        end
        e_data: if (stream_yumi_i) begin
          data_q   <= '0;
          rr_ptr_q <= (grant_q == id_w_lp'(num_req_p-1)) ? '0 : grant_q + 1'b1;
          state_q  <= e_idle;
        end
        default: state_q <= e_idle;
      endcase
    end
  end

  assign stream_v_o    = (state_q != e_idle);
  assign stream_data_o = data_q;
  assign push          = (state_q == e_data) && stream_yumi_i;

  always_comb begin
    req_yumi_o = '0;
    if (push) req_yumi_o[grant_q] = 1'b1;
  end

  always_comb begin
    tag_in    = '0;
    tag_in.id = bp_stream_arb_id_width_gp'(grant_q);
    tag_in.wr = wr_q;
  end

  bp_stream_arb_tag_queue #(.els_p(tag_els_p)) tag_queue (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (push),
    .data_i    (tag_in),
    .yumi_i    (pop),
    .data_o    (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    for (int i = 0; i < num_req_p; i++)
      head_oh[i] = !empty && (head.id == bp_stream_arb_id_width_gp'(i));
  end

  // Writes answer locally; reads pass the inbound beat straight through.
  always_comb begin
    resp_v_o       = '0;
    resp_data_o    = '0;
    stream_ready_o = 1'b0;
    pop            = 1'b0;
    if (!empty) begin
      if (head.wr) begin
        resp_v_o = head_oh;
        pop      = |(head_oh & resp_yumi_i);
      end else begin
        resp_v_o       = stream_v_i ? head_oh : '0;
        resp_data_o    = stream_data_i;
        stream_ready_o = |(head_oh & resp_yumi_i);
        pop            = stream_v_i && stream_ready_o;
      end
    end
  end

endmodule

// File: tb/tb_bp_stream_mmio_arbiter.sv
// Directed bench for bp_stream_mmio_arbiter: a cycle table for a single
// write, then hand-written sequences for arbitration, backpressure and reset.
module tb_bp_stream_mmio_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk, rst_n;
  logic [N-1:0]   req_v, req_wr, req_yumi, resp_v, resp_yumi;
  logic [N*W-1:0] req_addr, req_data;
  logic           s_v_o, s_yumi, s_v_i, s_ready;
  logic [W-1:0]   s_data_o, s_data_i, resp_data;

  int n_chk, n_fail;

  bp_stream_mmio_arbiter #(.num_req_p(N), .stream_data_width_p(W), .tag_els_p(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(req_v), .req_wr_i(req_wr), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_yumi_o(req_yumi),
    .stream_v_o(s_v_o), .stream_data_o(s_data_o), .stream_yumi_i(s_yumi),
    .stream_v_i(s_v_i), .stream_data_i(s_data_i), .stream_ready_o(s_ready),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_yumi_i(resp_yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h req=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_v = '0; req_wr = '0; s_yumi = 1'b1; s_v_i = 1'b0; s_data_i = '0; resp_yumi = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Called at posedge+1 with inputs applied; returns at posedge+1 of the
  // cycle after the consume pulse.
  task automatic wait_yumi(input string name, output logic [N-1:0] y);
    y = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_yumi != '0) begin
        y = req_yumi;
        tick();
        return;
      end
      tick();
    end
    chk({name, "_timeout"}, 32'(y), 32'hF);
  endtask

  typedef struct {
    logic [N-1:0] rv, rwr;
    logic         syumi;
    logic [N-1:0] ryumi;
    logic         e_sv;
    logic [W-1:0] e_sd;
    logic [N-1:0] e_ry, e_rv;
    logic [W-1:0] e_rd;
  } vec_t;

  vec_t tbl [6];
  logic [N-1:0] y;

  initial begin
    n_chk = 0; n_fail = 0;
    req_addr = '0; req_data = '0;
    do_reset();

    // Reset values
    chk("rst_stream_v", 32'(s_v_o), 0);
    chk("rst_stream_data", s_data_o, 0);
    chk("rst_req_yumi", 32'(req_yumi), 0);
    chk("rst_stream_ready", 32'(s_ready), 0);
    chk("rst_resp_v", 32'(resp_v), 0);
    chk("rst_resp_data", resp_data, 0);

    // Single write from requester 1, cycle by cycle
    req_addr[1*W +: W] = 32'h1000;
    req_data[1*W +: W] = 32'hDEAD_BEEF;
    tbl[0] = '{4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 32'h0};
    tbl[1] = '{4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b1, 32'h1000,      4'b0000, 4'b0000, 32'h0};
    tbl[2] = '{4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b1, 32'hDEAD_BEEF, 4'b0010, 4'b0000, 32'h0};
    tbl[3] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0010, 32'h0};
    tbl[4] = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 32'h0,         4'b0000, 4'b0010, 32'h0};
    tbl[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      req_v = tbl[i].rv; req_wr = tbl[i].rwr; s_yumi = tbl[i].syumi; resp_yumi = tbl[i].ryumi;
      #1;
      chk($sformatf("wr1_c%0d_stream_v", i), 32'(s_v_o), 32'(tbl[i].e_sv));
      chk($sformatf("wr1_c%0d_stream_data", i), s_data_o, tbl[i].e_sd);
      chk($sformatf("wr1_c%0d_req_yumi", i), 32'(req_yumi), 32'(tbl[i].e_ry));
      chk($sformatf("wr1_c%0d_resp_v", i), 32'(resp_v), 32'(tbl[i].e_rv));
      chk($sformatf("wr1_c%0d_resp_data", i), resp_data, tbl[i].e_rd);
      tick();
    end

    // Three contending reads: grant order 0, 2, 3; responses routed in order
    do_reset();
    req_v = 4'b1101; req_wr = '0;
    wait_yumi("rr_g0", y); chk("rr_grant0", 32'(y), 32'b0001); req_v = req_v & ~y;
    wait_yumi("rr_g1", y); chk("rr_grant1", 32'(y), 32'b0100); req_v = req_v & ~y;
    wait_yumi("rr_g2", y); chk("rr_grant2", 32'(y), 32'b1000); req_v = req_v & ~y;
    #1; chk("rr_resp_idle", 32'(resp_v), 0);
    tick();
    begin
      logic [N-1:0] dst [3];
      logic [W-1:0] wd  [3];
      dst[0] = 4'b0001; dst[1] = 4'b0100; dst[2] = 4'b1000;
      wd[0]  = 32'hA;   wd[1]  = 32'hB;   wd[2]  = 32'hC;
      for (int k = 0; k < 3; k++) begin
        s_v_i = 1'b1; s_data_i = wd[k]; resp_yumi = dst[k];
        #1;
        chk($sformatf("rr_resp%0d_v", k), 32'(resp_v), 32'(dst[k]));
        chk($sformatf("rr_resp%0d_data", k), resp_data, wd[k]);
        chk($sformatf("rr_resp%0d_ready", k), 32'(s_ready), 1);
        tick();
      end
      s_v_i = 1'b0; resp_yumi = '0;
      #1; chk("rr_drained", 32'(resp_v), 0);
      tick();
    end

    // Queue full: 16 reads outstanding block the 17th until one pops
    do_reset();
    req_addr[0*W +: W] = 32'h40;
    req_v = 4'b0001; req_wr = '0;
    for (int k = 0; k < 16; k++) begin
      wait_yumi("full_fill", y);
      if (y != 4'b0001) chk($sformatf("full_fill%0d", k), 32'(y), 32'b0001);
    end
    chk("full_16_issued", 32'(y), 32'b0001);
    begin
      logic blocked;
      blocked = 1'b0;
      for (int c = 0; c < 6; c++) begin
        #1; if (s_v_o || req_yumi != '0) blocked = 1'b1;
        tick();
      end
      chk("full_17th_blocked", 32'(blocked), 0);
    end
    s_v_i = 1'b1; s_data_i = 32'h123; resp_yumi = 4'b0001;
    #1;
    chk("full_pop_ready", 32'(s_ready), 1);
    chk("full_pop_stream_v", 32'(s_v_o), 0);
    tick();
    s_v_i = 1'b0; resp_yumi = '0;
    #1; chk("full_grant_cycle_v", 32'(s_v_o), 0);
    tick();
    #1;
    chk("full_17th_addr_v", 32'(s_v_o), 1);
    chk("full_17th_addr", s_data_o, 32'h40);
    tick();

    // Backpressure on the address beat
    do_reset();
    req_addr[2*W +: W] = 32'h2000;
    req_data[2*W +: W] = 32'h55;
    req_v = 4'b0100; req_wr = 4'b0100; s_yumi = 1'b0;
    tick();
    begin
      logic held_ok;
      held_ok = 1'b1;
      for (int c = 0; c < 5; c++) begin
        #1; if (!s_v_o || s_data_o != 32'h2000 || req_yumi != '0) held_ok = 1'b0;
        tick();
      end
      chk("stall_addr_held", 32'(held_ok), 1);
    end
    s_yumi = 1'b1;
    #1; chk("stall_addr_release", s_data_o, 32'h2000);
    tick();
    #1;
    chk("stall_data_beat", s_data_o, 32'h55);
    chk("stall_data_yumi", 32'(req_yumi), 32'b0100);
    tick();
    req_v = '0;

    // Write then read: write response first, inbound held off until it pops
    do_reset();
    req_addr[0*W +: W] = 32'h10; req_data[0*W +: W] = 32'h99;
    req_addr[1*W +: W] = 32'h20;
    req_v = 4'b0011; req_wr = 4'b0001; s_v_i = 1'b1; s_data_i = 32'h77;
    wait_yumi("wr_rd_g0", y); chk("wr_rd_grant0", 32'(y), 32'b0001); req_v = req_v & ~y;
    wait_yumi("wr_rd_g1", y); chk("wr_rd_grant1", 32'(y), 32'b0010); req_v = req_v & ~y;
    #1;
    chk("wr_rd_head_v", 32'(resp_v), 32'b0001);
    chk("wr_rd_head_data", resp_data, 0);
    chk("wr_rd_head_ready", 32'(s_ready), 0);
    tick();
    resp_yumi = 4'b0001;
    #1; chk("wr_rd_wpop_ready", 32'(s_ready), 0);
    tick();
    resp_yumi = 4'b0010;
    #1;
    chk("wr_rd_read_v", 32'(resp_v), 32'b0010);
    chk("wr_rd_read_data", resp_data, 32'h77);
    chk("wr_rd_read_ready", 32'(s_ready), 1);
    tick();
    resp_yumi = '0; s_v_i = 1'b0;
    #1; chk("wr_rd_empty", 32'(resp_v), 0);
    tick();

    // Reset mid-DATA with rr_ptr advanced and a tag outstanding
    do_reset();
    req_v = 4'b0001; req_wr = '0;
    wait_yumi("rst_pre", y); chk("rst_pre_grant", 32'(y), 32'b0001);
    req_addr[1*W +: W] = 32'h3000; req_data[1*W +: W] = 32'h4444;
    req_v = 4'b0010; req_wr = 4'b0010;
    tick(); tick();
    #1; chk("rst_in_data", s_data_o, 32'h4444);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stream_v", 32'(s_v_o), 0);
    chk("rst_mid_stream_data", s_data_o, 0);
    chk("rst_mid_req_yumi", 32'(req_yumi), 0);
    chk("rst_mid_resp_v", 32'(resp_v), 0);
    chk("rst_mid_ready", 32'(s_ready), 0);
    tick();
    rst_n = 1'b1;
    req_v = 4'b0011; req_wr = '0;
    wait_yumi("rst_post", y); chk("rst_post_grant", 32'(y), 32'b0001);
    req_v = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
